// File: rtl/sample_accum_pkg.sv
// Shared types and constants for the sample accumulator.
// The SATURATE_EN macro (see the top module) selects a saturating sum instead of a wrapping one.
package sample_accum_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } accum_state_t;

   localparam int unsigned DATA_W = 16;
   localparam logic [DATA_W-1:0] SAT_VAL = 16'hFFFF;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit unsigned adder with carry-in; overflow is the carry-out of the MSB.
module adder_16bit
   import sample_accum_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              carry_in,
   output logic [DATA_W-1:0] sum,
   output logic              overflow
);

   always_comb begin
      {overflow, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, carry_in};
   end

endmodule

// File: rtl/sample_accumulator_16bit.sv
// Sums NUM_SAMPLES unsigned samples per batch and hands the result over a valid/ready handshake.
// Define SATURATE_EN to clamp the sum at SAT_VAL once any add carries out; otherwise it wraps.
module sample_accumulator_16bit
   import sample_accum_pkg::*;
#(
   parameter int unsigned NUM_SAMPLES = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] acc_sum,
   output logic              acc_overflow,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
   localparam logic [CW:0] LAST = (CW + 1)'(NUM_SAMPLES);

   accum_state_t      state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              ovf_q, ovf_d;
   logic [CW-1:0]     count_q, count_d;

   logic [DATA_W-1:0] add_sum;
   logic              add_carry;
   logic [DATA_W-1:0] add_val;
   logic [CW:0]       count_inc;

   adder_16bit u_adder (
      .a        (acc_q),
      .b        (in_data),
      .carry_in (1'b0),
      .sum      (add_sum),
      .overflow (add_carry)
   );

`ifdef SATURATE_EN
   // Once the batch has carried out, stay pinned at the saturation value.
   assign add_val = (ovf_q | add_carry) ? SAT_VAL : add_sum;
`else
   assign add_val = add_sum;
`endif

   assign count_inc = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      if (clear) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         count_d = '0;
      end else begin
         case (state_q)
            IDLE, ACCUM: begin
               if (in_valid) begin
                  acc_d   = add_val;
                  ovf_d   = ovf_q | add_carry;
                  count_d = count_inc[CW-1:0];
                  state_d = (count_inc == LAST) ? DONE : ACCUM;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  count_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         count_q <= count_d;
      end
   end

   assign in_ready     = (state_q != DONE);
   assign out_valid    = (state_q == DONE);
   assign acc_sum      = acc_q;
   assign acc_overflow = ovf_q;

endmodule

// File: tb/tb_sample_accumulator_16bit.sv
// Directed bench for sample_accumulator_16bit: a 4-sample instance plus a 1-sample instance.
module tb_sample_accumulator_16bit;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic [15:0] acc_sum;
   logic        acc_overflow;
   logic        out_valid;

   logic        clear1 = 1'b0;
   logic [15:0] in_data1 = '0;
   logic        in_valid1 = 1'b0;
   logic        out_ready1 = 1'b0;
   logic        in_ready1;
   logic [15:0] acc_sum1;
   logic        acc_overflow1;
   logic        out_valid1;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sample_accumulator_16bit #(.NUM_SAMPLES(4)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .acc_sum      (acc_sum),
      .acc_overflow (acc_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   sample_accumulator_16bit #(.NUM_SAMPLES(1)) dut1 (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (clear1),
      .in_data      (in_data1),
      .in_valid     (in_valid1),
      .in_ready     (in_ready1),
      .acc_sum      (acc_sum1),
      .acc_overflow (acc_overflow1),
      .out_valid    (out_valid1),
      .out_ready    (out_ready1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [15:0] d);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] exp3;
`ifdef SATURATE_EN
      exp3 = 16'hFFFF;
`else
      exp3 = 16'h2223;
`endif
      // Test 1: asynchronous reset in the middle of a batch
      #12 n_rst = 1'b1;
      tick();
      feed(16'h0009);
      feed(16'h0008);
      check("pre_rst_sum", acc_sum, 32'h11);
      #2 n_rst = 1'b0;
      #1;
      check("rst_sum", acc_sum, 0);
      check("rst_ovf", acc_overflow, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      n_rst = 1'b1;
      tick();

      // Test 2: basic back-to-back batch
      feed(16'h0001);
      check("b2b_lat1", acc_sum, 32'h1);
      feed(16'h0002);
      feed(16'h0003);
      check("b2b_sum3", acc_sum, 32'h6);
      check("b2b_ov_early", out_valid, 0);
      feed(16'h0004);
      check("b2b_out_valid", out_valid, 1);
      check("b2b_sum", acc_sum, 32'hA);
      check("b2b_ovf", acc_overflow, 0);

      // Test 4: backpressure in DONE with ignored input samples
      for (int i = 0; i < 5; i++) begin
         in_data  = 16'h1111;
         in_valid = i[0] ? 1'b0 : 1'b1;
         tick();
         check("bp_sum", acc_sum, 32'hA);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      drain();
      check("bp_rel_out_valid", out_valid, 0);
      check("bp_rel_sum", acc_sum, 0);
      check("bp_rel_in_ready", in_ready, 1);

      // Test 3: overflow batch
      feed(16'hFDBA);
      feed(16'h0123);
      check("ovf_mid_sum", acc_sum, 32'hFEDD);
      check("ovf_mid_flag", acc_overflow, 0);
      feed(16'h2345);
      check("ovf_flag_set", acc_overflow, 1);
      feed(16'h0001);
      check("ovf_sum", acc_sum, {16'h0, exp3});
      check("ovf_flag", acc_overflow, 1);
      check("ovf_out_valid", out_valid, 1);
      drain();
      check("ovf_cleared", acc_overflow, 0);

      // Test 5: clear mid-batch outranks a simultaneous sample
      feed(16'h0005);
      feed(16'h0006);
      clear    = 1'b1;
      in_data  = 16'h0007;
      in_valid = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_sum", acc_sum, 0);
      check("clr_in_ready", in_ready, 1);
      check("clr_out_valid", out_valid, 0);
      feed(16'h0001);
      feed(16'h0002);
      feed(16'h0003);
      check("clr_cnt_reset", out_valid, 0);
      feed(16'h0004);
      check("clr_fresh_valid", out_valid, 1);
      check("clr_fresh_sum", acc_sum, 32'hA);
      // clear in DONE discards the result even with out_ready high
      clear     = 1'b1;
      out_ready = 1'b1;
      tick();
      clear     = 1'b0;
      out_ready = 1'b0;
      check("clr_done_valid", out_valid, 0);
      check("clr_done_sum", acc_sum, 0);

      // Test 6: gaps between samples, out_ready high outside DONE
      out_ready = 1'b1;
      feed(16'h0001);
      tick();
      check("gap_hold", acc_sum, 32'h1);
      feed(16'h0002);
      tick();
      tick();
      feed(16'h0003);
      check("gap_ov_early", out_valid, 0);
      feed(16'h0004);
      check("gap_out_valid", out_valid, 1);
      check("gap_sum", acc_sum, 32'hA);
      tick();
      out_ready = 1'b0;
      check("gap_drained", out_valid, 0);

      // NUM_SAMPLES=1 instance
      in_data1  = 16'hABCD;
      in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      check("one_out_valid", out_valid1, 1);
      check("one_sum", acc_sum1, 32'hABCD);
      check("one_in_ready", in_ready1, 0);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      check("one_drained", out_valid1, 0);
      check("one_sum_clr", acc_sum1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
